// File: rtl/fpga_ctrl_pkg.sv
// Shared register map, field offsets and constants for the capture control/status register file.
package fpga_ctrl_pkg;

    typedef enum logic [3:0] {
        CTRL       = 4'd0,
        STATUS     = 4'd1,
        BATCH_SIZE = 4'd2,
        IRQ_EN     = 4'd3,
        ID         = 4'd4,
        SCRATCH    = 4'd5
    } reg_addr_e;

    localparam int MOCK_EN_BIT    = 8;
    localparam int FIFO_RST_LSB   = 16;
    localparam int DONE_LSB       = 8;
    localparam int LIVE_READY_LSB = 16;
    localparam int SDRAM_BUSY_BIT = 24;

    localparam logic [31:0] BAD_ADDR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/fpga_ctrl_regs_status_sticky.sv
// One sticky status bit: registers its input, optionally edge-detects it, and holds it
// until a write-1-to-clear; a new set event in the clearing cycle wins.
module status_sticky #(
    parameter bit EDGE_DETECT = 1'b0
) (
    input  logic i_clk,
    input  logic i_areset_n,
    input  logic i_in,
    input  logic i_clr,
    output logic o_sticky
);

    logic in_q;
    logic sticky_q;
    logic sticky_d;
    logic set_evt;

    generate
        if (EDGE_DETECT) begin : g_edge
            logic prev_q;
            always_ff @(posedge i_clk or negedge i_areset_n) begin
                if (!i_areset_n) prev_q <= 1'b0;
                else             prev_q <= in_q;
            end
            assign set_evt = in_q & ~prev_q;
        end else begin : g_level
            assign set_evt = in_q;
        end
    endgenerate

    always_comb begin
        sticky_d = set_evt | (sticky_q & ~i_clr);
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            in_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            in_q     <= i_in;
            sticky_q <= sticky_d;
        end
    end

    assign o_sticky = sticky_q;

endmodule

// File: rtl/fpga_ctrl_regs.sv
// Bus-facing control/status register file for the multi-channel capture datapath:
// control outputs, W1C sticky status per channel, maskable level interrupt.
module fpga_ctrl_regs
    import fpga_ctrl_pkg::*;
#(
    parameter int          ADDR_SIZE          = 4,
    parameter int          REG_SIZE           = 32,
    parameter int          NUM_CH             = 2,
    parameter int          BATCH_W            = 16,
    parameter int          DEFAULT_BATCH_SIZE = 1024,
    parameter logic [31:0] VERSION            = 32'h0002_0000
) (
    input  logic                 i_clk,
    input  logic                 i_areset_n,
    input  logic                 i_write_en,
    input  logic                 i_read_en,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic [REG_SIZE-1:0]  i_write_data,
    output logic [REG_SIZE-1:0]  o_read_data,
    output logic                 o_read_valid,
    output logic [NUM_CH-1:0]    o_capture_enable,
    output logic                 o_mock_enable,
    output logic [NUM_CH-1:0]    o_reset_fifo,
    output logic [BATCH_W-1:0]   o_batch_size,
    output logic                 o_irq,
    input  logic [NUM_CH-1:0]    i_fifo_overflow,
    input  logic [NUM_CH-1:0]    i_batch_ready,
    input  logic                 i_sdram_busy
);

    logic [NUM_CH-1:0]   cap_en_q, cap_en_d;
    logic                mock_q, mock_d;
    logic [NUM_CH-1:0]   fifo_rst_q, fifo_rst_d;
    logic [BATCH_W-1:0]  batch_q, batch_d;
    logic [NUM_CH-1:0]   ovf_mask_q, ovf_mask_d;
    logic [NUM_CH-1:0]   done_mask_q, done_mask_d;
    logic [REG_SIZE-1:0] scratch_q, scratch_d;
    logic [REG_SIZE-1:0] rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                irq_q, irq_d;
    logic [NUM_CH-1:0]   ready_live_q;
    logic                busy_q;

    logic                wr_ctrl, wr_status, wr_batch, wr_irq_en, wr_scratch;
    logic [NUM_CH-1:0]   ovf_clr, done_clr;
    logic [NUM_CH-1:0]   ovf_sticky, done_sticky;
    logic [REG_SIZE-1:0] rd_mux;

    always_comb begin
        wr_ctrl    = i_write_en && (i_addr == ADDR_SIZE'(CTRL));
        wr_status  = i_write_en && (i_addr == ADDR_SIZE'(STATUS));
        wr_batch   = i_write_en && (i_addr == ADDR_SIZE'(BATCH_SIZE));
        wr_irq_en  = i_write_en && (i_addr == ADDR_SIZE'(IRQ_EN));
        wr_scratch = i_write_en && (i_addr == ADDR_SIZE'(SCRATCH));
        ovf_clr    = wr_status ? i_write_data[NUM_CH-1:0] : '0;
        done_clr   = wr_status ? i_write_data[DONE_LSB +: NUM_CH] : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            status_sticky #(.EDGE_DETECT(1'b0)) u_ovf (
                .i_clk      (i_clk),
                .i_areset_n (i_areset_n),
                .i_in       (i_fifo_overflow[gi]),
                .i_clr      (ovf_clr[gi]),
                .o_sticky   (ovf_sticky[gi])
            );
            status_sticky #(.EDGE_DETECT(1'b1)) u_done (
                .i_clk      (i_clk),
                .i_areset_n (i_areset_n),
                .i_in       (i_batch_ready[gi]),
                .i_clr      (done_clr[gi]),
                .o_sticky   (done_sticky[gi])
            );
        end
    endgenerate

    // Read mux sees pre-write state, giving read-before-write on a same-cycle access.
    always_comb begin
        rd_mux = '0;
        case (i_addr)
            ADDR_SIZE'(CTRL): begin
                rd_mux[NUM_CH-1:0]  = cap_en_q;
                rd_mux[MOCK_EN_BIT] = mock_q;
            end
            ADDR_SIZE'(STATUS): begin
                rd_mux[NUM_CH-1:0]              = ovf_sticky;
                rd_mux[DONE_LSB +: NUM_CH]       = done_sticky;
                rd_mux[LIVE_READY_LSB +: NUM_CH] = ready_live_q;
                rd_mux[SDRAM_BUSY_BIT]           = busy_q;
            end
            ADDR_SIZE'(BATCH_SIZE): rd_mux[BATCH_W-1:0] = batch_q;
            ADDR_SIZE'(IRQ_EN): begin
                rd_mux[NUM_CH-1:0]        = ovf_mask_q;
                rd_mux[DONE_LSB +: NUM_CH] = done_mask_q;
            end
            ADDR_SIZE'(ID):      rd_mux = REG_SIZE'(VERSION);
            ADDR_SIZE'(SCRATCH): rd_mux = scratch_q;
            default:             rd_mux = REG_SIZE'(BAD_ADDR_DATA);
        endcase
    end

    always_comb begin
        cap_en_d    = wr_ctrl ? i_write_data[NUM_CH-1:0] : cap_en_q;
        mock_d      = wr_ctrl ? i_write_data[MOCK_EN_BIT] : mock_q;
        fifo_rst_d  = wr_ctrl ? i_write_data[FIFO_RST_LSB +: NUM_CH] : '0;
        batch_d     = (wr_batch && (i_write_data[BATCH_W-1:0] != '0)) ? i_write_data[BATCH_W-1:0] : batch_q;
        ovf_mask_d  = wr_irq_en ? i_write_data[NUM_CH-1:0] : ovf_mask_q;
        done_mask_d = wr_irq_en ? i_write_data[DONE_LSB +: NUM_CH] : done_mask_q;
        scratch_d   = wr_scratch ? i_write_data : scratch_q;
        rdata_d     = i_read_en ? rd_mux : rdata_q;
        rvalid_d    = i_read_en;
        irq_d       = (|(ovf_sticky & ovf_mask_q)) | (|(done_sticky & done_mask_q));
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            cap_en_q     <= '0;
            mock_q       <= 1'b0;
            fifo_rst_q   <= '0;
            batch_q      <= BATCH_W'(DEFAULT_BATCH_SIZE);
            ovf_mask_q   <= '0;
            done_mask_q  <= '0;
            scratch_q    <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            irq_q        <= 1'b0;
            ready_live_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            cap_en_q     <= cap_en_d;
            mock_q       <= mock_d;
            fifo_rst_q   <= fifo_rst_d;
            batch_q      <= batch_d;
            ovf_mask_q   <= ovf_mask_d;
            done_mask_q  <= done_mask_d;
            scratch_q    <= scratch_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            irq_q        <= irq_d;
            ready_live_q <= i_batch_ready;
            busy_q       <= i_sdram_busy;
        end
    end

    assign o_capture_enable = cap_en_q;
    assign o_mock_enable    = mock_q;
    assign o_reset_fifo     = fifo_rst_q;
    assign o_batch_size     = batch_q;
    assign o_irq            = irq_q;
    assign o_read_data      = rdata_q;
    assign o_read_valid     = rvalid_q;

endmodule
